shift_unit_seq: RTL and testbench
=================================

# shift_unit_seq

Parametrised, multi-cycle shift unit for the miniRISC datapath, successor to the single-cycle combinational logical right shifter. It performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. Shifting is done iteratively, at most STEP bits per cycle, which keeps the critical path short. Operands enter and results leave through valid/ready handshakes, so the unit can sit behind the ALU issue stage and stall it.

## Interface
Parameters:
- WIDTH, 32: operand width; power of two, ≥ 8.
- STEP, 4: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SW (localparam), $clog2(WIDTH): shift-amount width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  unit can accept an operand.
- in_data  in  WIDTH  operand.
- in_shamt  in  SW  shift amount, 0..WIDTH-1.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  result.
- busy  out  1  high in SHIFT or DONE.

## Operation
- Accept: in_valid & in_ready. Latch in_data into acc, in_shamt into rem, and in_op into op.
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on accept with in_shamt ≠ 0.
- IDLE → DONE on accept with in_shamt = 0. The result is in_data unchanged.
- SHIFT: each cycle, k = min(STEP, rem). acc ← step(acc, k, op) and rem ← rem − k.
- SHIFT → DONE when rem − k = 0.
- Per-op step rules:
  - SLL: fill with 0 from the LSB side.
  - SRL: fill with 0 from the MSB side.
  - SRA: fill with acc[WIDTH-1]. The sign stays correct across iterations because the MSB is preserved.
  - ROR: bits leaving the LSB re-enter at the MSB.
- DONE: out_valid = 1 and out_data = acc, both held stable until out_ready.
- DONE → IDLE on out_valid & out_ready.
- in_ready = (state == IDLE). No operand is accepted in SHIFT or DONE, including the cycle a result is consumed.
- in_op, in_shamt and in_data are ignored when no accept occurs. Inputs changing mid-operation have no effect.
- Width rules:
  - k is SW+1 bits wide internally, so STEP = WIDTH does not overflow.
  - rem never underflows.
  - The result is always exactly WIDTH bits; no carry-out.
- Reset, at any time including mid-SHIFT or in DONE:
  - state = IDLE.
  - acc = 0, rem = 0, op = SLL.
  - out_valid = 0, out_data = 0, busy = 0, in_ready = 1 after reset deasserts.
  - Any in-flight operation is discarded silently.

## Timing
- Accept at edge t, with n = ceil(in_shamt / STEP):
  - out_valid is first high in the cycle after edge t+n+1 − 1, i.e. latency n+1 cycles.
  - in_shamt = 0 gives latency 1.
- Next accept is possible no earlier than the cycle after the result handshake.
- Minimum issue interval is n+2 cycles.
- Output back-pressure (out_ready = 0) holds DONE indefinitely with no loss.
- out_data is registered (acc); there is no combinational path from inputs to outputs.
- in_ready and busy decode directly from state registers.
- Worst case, in_shamt = WIDTH−1: WIDTH=32, STEP=4 gives n = 8, latency 9.

## Structure
- Package shift_pkg holds:
  - shift_op_t enum: SLL=2'b00, SRL=2'b01, SRA=2'b10, ROR=2'b11.
  - shift_state_t enum: IDLE, SHIFT, DONE.
- One sub-module, shift_step:
  - Purely combinational.
  - Inputs: acc[WIDTH], k (SW+1 bits, ≤ STEP), op.
  - Output: the shifted value.
  - Implemented as a log2(STEP)+1-stage mux chain, not a generic `>>` on a SW-bit amount.
- Top level contains only the FSM, the acc/rem/op registers and the handshake logic.

## Test plan
- SRL, WIDTH=32, STEP=4: in_data=0xF000_0000, in_shamt=5 → out_data=0x0780_0000; out_valid at latency 3 (n=2).
- SRA, in_data=0x8000_0000, in_shamt=31 → out_data=0xFFFF_FFFF, latency 9. Repeat with SLL, in_data=0x0000_0001, in_shamt=31 → 0x8000_0000.
- ROR, in_data=0x0000_00A5, in_shamt=4 → 0x5000_000A, latency 2. Repeat with in_shamt=0 → 0x0000_00A5, latency 1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0 throughout. Release → out_valid drops the next cycle and in_ready=1. A new in_valid asserted during DONE is not accepted.
- Reset mid-SHIFT: assert rst asynchronously 2 cycles into a shamt=20 operation → out_valid=0, out_data=0, busy=0 immediately. After release, a fresh SLL 0x1 by 1 → 0x2 at latency 2.
- Sweep: STEP ∈ {1, 4, 32}, random data/shamt/op over 1000 operations against a golden model → results match, and latency = ceil(shamt/STEP)+1 every time.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit: operation encodings and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift unit: shifts acc_i by k_i (<= STEP) bits using a
// log2(STEP)+1 stage mux chain, one stage per power-of-two weight of k_i.
module shift_step
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [SW:0]      k_i,
  input  shift_op_t        op_i,
  output logic [WIDTH-1:0] res_o
);

  localparam int NST = $clog2(STEP) + 1;

  logic [NST:0][WIDTH-1:0] stg;

  assign stg[0] = acc_i;

  for (genvar j = 0; j < NST; j++) begin : g_stage
    localparam int S = 1 << j;

    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] shf;

    // A full-width rotate is the identity; only reachable when STEP == WIDTH.
    if (S < WIDTH) begin : g_rot
      assign rot = {stg[j][S-1:0], stg[j][WIDTH-1:S]};
    end else begin : g_full
      assign rot = stg[j];
    end

    always_comb begin
      shf = stg[j];
      unique case (op_i)
        SLL: shf = stg[j] << S;
        SRL: shf = stg[j] >> S;
        SRA: shf = WIDTH'($signed(stg[j]) >>> S);
        ROR: shf = rot;
      endcase
    end

    assign stg[j+1] = k_i[j] ? shf : stg[j];
  end

  assign res_o = stg[NST];

  // Bits of k_i above the largest stage weight are always zero because k_i <= STEP.
  if (NST <= SW) begin : g_k_hi
    logic unused_k_hi;
    assign unused_k_hi = ^k_i[SW:NST];
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit (SLL/SRL/SRA/ROR) with valid/ready handshakes on both sides;
// shifts at most STEP bits per cycle through the shift_step datapath.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [SW:0] STEP_K = (SW+1)'(STEP);

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    rem_q, rem_d;
  shift_op_t        op_q, op_d;

  logic [SW:0]      rem_ext;
  logic [SW:0]      k;
  logic [SW-1:0]    rem_next;
  logic [WIDTH-1:0] step_res;

  // k is one bit wider than rem so STEP == WIDTH is representable; k <= rem always.
  assign rem_ext  = {1'b0, rem_q};
  assign k        = (rem_ext > STEP_K) ? STEP_K : rem_ext;
  assign rem_next = rem_q - k[SW-1:0];

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc_i (acc_q),
    .k_i   (k),
    .op_i  (op_q),
    .res_o (step_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= SLL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          rem_d   = in_shamt;
          op_d    = shift_op_t'(in_op);
          state_d = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d = step_res;
        rem_d = rem_next;
        if (rem_next == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: directed vectors on a STEP=4 instance plus
// random sweeps on STEP=1, 4 and 32 instances against a reference shift model.
module tb_shift_unit_seq;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] e;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] o);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $signed(d) >>> s;
      default: return (d >> s) | (d << (32 - int'(s)));
    endcase
  endfunction

  // ---------------- main STEP=4 instance ----------------
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        rst_s;

  shift_unit_seq #(.WIDTH(32), .STEP(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  exp_t q[$];
  int   acc_c, first_c;
  bit   vseen = 0;

  always @(negedge clk) begin
    if (rst) begin
      vseen = 0;
    end else begin
      if (in_valid && in_ready) acc_c = cyc + 1;
      if (out_valid && !vseen) begin
        vseen   = 1;
        first_c = cyc;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check32("unexpected_out", 32'(q.size()), 32'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          check32("data", out_data, e.data);
          check32("latency", 32'(first_c - acc_c + 1), 32'(e.lat));
        end
        vseen = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                       input logic [31:0] e, input int lat, input bit push);
    bit got = 0;
    int n   = 0;
    if (push) q.push_back('{e, lat});
    in_data  = d;
    in_shamt = s;
    in_op    = o;
    in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check32("accept", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check32("drain", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10] = '{
    '{SRL, 32'hF000_0000, 5'd5,  32'h0780_0000, 3},
    '{SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9},
    '{SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 9},
    '{ROR, 32'h0000_00A5, 5'd4,  32'h5000_000A, 2},
    '{ROR, 32'h0000_00A5, 5'd0,  32'h0000_00A5, 1},
    '{SRA, 32'h7000_0000, 5'd8,  32'h0070_0000, 3},
    '{SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 9},
    '{ROR, 32'h1234_5678, 5'd16, 32'h5678_1234, 5},
    '{SLL, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 3},
    '{SRA, 32'hF000_0000, 5'd3,  32'hFE00_0000, 2}
  };

  initial begin
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  o;
    int          n;
    rst = 1'b1; rst_s = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst_s = 1'b0;

    @(negedge clk);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_out_data", out_data, 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i].d, vecs[i].s, vecs[i].op, vecs[i].e, vecs[i].lat, 1'b1);
      drain();
    end

    // back-pressure: DONE held, second operand presented but not taken
    out_ready = 1'b0;
    issue(32'h0000_1234, 5'd8, SLL, 32'h0012_3400, 3, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check32("bp_wait_valid", 32'(out_valid), 32'd1);
    in_data = 32'hFFFF_FFFF; in_shamt = 5'd3; in_op = SRL; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check32("bp_data", out_data, 32'h0012_3400);
      check32("bp_in_ready", 32'(in_ready), 32'd0);
      check32("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check32("bp_release_valid", 32'(out_valid), 32'd0);
    check32("bp_release_ready", 32'(in_ready), 32'd1);
    drain();

    // asynchronous reset two cycles into a long shift
    issue(32'hDEAD_BEEF, 5'd20, SLL, '0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check32("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check32("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check32("mid_rst_out_data", out_data, 32'd0);
    check32("mid_rst_busy", 32'(busy), 32'd0);
    check32("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'h0000_0001, 5'd1, SLL, 32'h0000_0002, 2, 1'b1);
    drain();

    for (int i = 0; i < 334; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      o = 2'($urandom_range(0, 3));
      issue(d, s, o, ref_shift(d, s, o), (int'(s) + 3) / 4 + 1, 1'b1);
    end
    drain();

    n = 0;
    while (!(gen_sw[0].done && gen_sw[1].done) && n < 40000) begin
      @(posedge clk);
      n++;
    end
    check32("sweep_complete", 32'(gen_sw[0].done && gen_sw[1].done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- sweep instances: STEP=1 and STEP=32 ----------------
  for (genvar g = 0; g < 2; g++) begin : gen_sw
    localparam int ST = (g == 0) ? 1 : 32;

    logic        iv, ir, ov, bz;
    logic        orr = 1'b1;
    logic [31:0] id, od;
    logic [4:0]  is;
    logic [1:0]  io;
    bit          done = 0;
    exp_t        sq[$];
    int          sacc_c, sfirst_c;
    bit          svseen = 0;

    shift_unit_seq #(.WIDTH(32), .STEP(ST)) u_dut (
      .clk       (clk),
      .rst       (rst_s),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .in_shamt  (is),
      .in_op     (io),
      .out_valid (ov),
      .out_ready (orr),
      .out_data  (od),
      .busy      (bz)
    );

    always @(posedge clk) begin
      #1;
      orr = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (!rst_s) begin
        if (iv && ir) sacc_c = cyc + 1;
        if (ov && !svseen) begin
          svseen   = 1;
          sfirst_c = cyc;
        end
        if (ov && orr) begin
          if (sq.size() == 0) begin
            check32("sweep_unexpected_out", 32'(sq.size()), 32'd1);
          end else begin
            exp_t e;
            e = sq.pop_front();
            check32("sweep_data", od, e.data);
            check32("sweep_latency", 32'(sfirst_c - sacc_c + 1), 32'(e.lat));
          end
          svseen = 0;
        end
      end
    end

    initial begin
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  o;
      bit          got;
      int          n;
      iv = 1'b0; id = '0; is = '0; io = '0;
      wait (!rst_s);
      @(posedge clk);
      #1;
      for (int i = 0; i < 334; i++) begin
        d = $urandom;
        s = 5'($urandom_range(0, 31));
        o = 2'($urandom_range(0, 3));
        sq.push_back('{ref_shift(d, s, o), (int'(s) + ST - 1) / ST + 1});
        id = d; is = s; io = o; iv = 1'b1;
        got = 0;
        n   = 0;
        while (!got && n < 200) begin
          @(negedge clk);
          got = ir;
          @(posedge clk);
          #1;
          n++;
        end
        iv = 1'b0;
        check32("sweep_accept", 32'(got), 32'd1);
      end
      n = 0;
      while (sq.size() != 0 && n < 400) begin
        @(posedge clk);
        n++;
      end
      check32("sweep_drain", 32'(sq.size()), 32'd0);
      done = 1;
    end
  end

endmodule
